// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between NUM_REQ burst fetchers; one read per cycle.
// Beats return ROM_LATENCY cycles after each read; no backpressure, consumers take every valid beat.
module rom_read_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 14,
    parameter int NUM_REQ     = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int ROM_LATENCY = 1,
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         rom_address,
    output logic                          rom_rden,
    input  logic [DATA_WIDTH-1:0]         rom_q,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [ID_WIDTH-1:0]           rd_id,
    output logic                          rd_last,
    output logic [NUM_REQ-1:0]            done
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   id_r;
    logic [LEN_WIDTH-1:0]  rem;
    logic                  zero_len;
    logic [ROM_LATENCY-1:0] vld_pipe;
    logic [ROM_LATENCY-1:0] last_pipe;
    logic [ID_WIDTH-1:0]   id_pipe [ROM_LATENCY];

    logic                  any_req;
    logic                  found;
    logic [ID_WIDTH-1:0]   win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [LEN_WIDTH-1:0]  win_len;
    logic                  last_in;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign any_req  = |req;
    assign win_addr = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len  = req_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign last_in  = rom_rden && (rem == LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            id_r        <= '0;
            rem         <= '0;
            zero_len    <= 1'b0;
            rom_rden    <= 1'b0;
            rom_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant  <= NUM_REQ'(1) << win_idx;
                        id_r   <= win_idx;
                        rr_ptr <= (win_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                        if (win_len == '0) begin
                            zero_len <= 1'b1;
                            state    <= DRAIN;
                        end else begin
                            rom_rden    <= 1'b1;
                            rom_address <= win_addr;
                            rem         <= win_len;
                            state       <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (rem == LEN_WIDTH'(1)) begin
                        rom_rden <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        rom_address <= rom_address + 1'b1;
                        rem         <= rem - 1'b1;
                    end
                end
                DRAIN: begin
                    if (zero_len || rd_last) begin
                        grant    <= '0;
                        zero_len <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat qualifiers follow the ROM's fixed latency so they line up with rom_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) id_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= rom_rden;
            last_pipe[0] <= last_in;
            id_pipe[0]   <= id_r;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                id_pipe[i]   <= id_pipe[i-1];
            end
        end
    end

    assign rd_valid = vld_pipe[ROM_LATENCY-1];
    assign rd_last  = last_pipe[ROM_LATENCY-1];
    assign rd_id    = id_pipe[ROM_LATENCY-1];
    assign rd_data  = rom_q;
    assign busy     = (state != IDLE);
    assign done     = grant & {NUM_REQ{(state == DRAIN) && (zero_len || rd_last)}};

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench: one arbiter with a 1-cycle ROM, one with a 2-cycle ROM, each backed by a behavioural ROM.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [3:0]  req = '0,  req2 = '0;
    logic [55:0] req_addr = '0, req_addr2 = '0;
    logic [31:0] req_len = '0,  req_len2 = '0;
    logic [3:0]  grant, grant2, done, done2;
    logic        busy, busy2, rom_rden, rom_rden2, rd_valid, rd_valid2, rd_last, rd_last2;
    logic [13:0] rom_address, rom_address2;
    logic [15:0] rom_q, rom_q2, q2a, rd_data, rd_data2;
    logic [1:0]  rd_id, rd_id2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_read_arbiter #(.ROM_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .grant(grant), .busy(busy), .rom_address(rom_address), .rom_rden(rom_rden),
        .rom_q(rom_q), .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
        .rd_last(rd_last), .done(done));

    rom_read_arbiter #(.ROM_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .req_addr(req_addr2), .req_len(req_len2),
        .grant(grant2), .busy(busy2), .rom_address(rom_address2), .rom_rden(rom_rden2),
        .rom_q(rom_q2), .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_id(rd_id2),
        .rd_last(rd_last2), .done(done2));

    function automatic logic [15:0] romf(logic [13:0] a);
        return {2'b10, a} ^ 16'h1234;
    endfunction

    always @(posedge clk) begin
        if (rom_rden) rom_q <= romf(rom_address);
        if (rom_rden2) q2a <= romf(rom_address2);
        rom_q2 <= q2a;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(int i, logic [13:0] a, logic [7:0] l);
        req[i] = 1'b1;
        req_addr[i*14 +: 14] = a;
        req_len[i*8 +: 8] = l;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((busy || busy2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_timeout", {30'd0, busy, busy2}, 32'd0);
    endtask

    task automatic burst(int i, logic [13:0] a, logic [7:0] l);
        int  nrd = 0;
        int  nbt = 0;
        int  cyc = 0;
        bit  fin = 1'b0;
        post(i, a, l);
        while (!fin && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rom_rden) begin
                chk("burst_addr", rom_address, 14'(a + nrd));
                nrd++;
            end
            if (rd_valid) begin
                chk("burst_data", rd_data, romf(14'(a + nbt)));
                chk("burst_id", rd_id, i);
                nbt++;
                chk("burst_last", rd_last, nbt == int'(l));
            end
            if (done != 0) begin
                chk("burst_done", done, 32'd1 << i);
                fin = 1'b1;
                req[i] = 1'b0;
            end
        end
        chk("burst_timeout", fin, 1);
        chk("burst_nreads", nrd, l);
        chk("burst_nbeats", nbt, l);
        wait_idle();
    endtask

    initial begin
        logic [3:0] got [5];
        logic [3:0] prev;
        int n, cyc, overlap;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rden", rom_rden, 0);
        chk("rst_addr", rom_address, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_done", done, 0);
        chk("rst_id", rd_id, 0);
        reset_n = 1'b1;

        // 1: requester 2, len 4, exact cycle timing
        @(negedge clk);
        post(2, 14'h0010, 8'd4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t1_grant", grant, (c <= 5) ? 4'b0100 : 4'b0000);
            chk("t1_busy", busy, c <= 5);
            chk("t1_rden", rom_rden, c <= 4);
            if (c <= 4) chk("t1_addr", rom_address, 14'h0010 + c - 1);
            chk("t1_valid", rd_valid, (c >= 2) && (c <= 5));
            if (c >= 2 && c <= 5) begin
                chk("t1_data", rd_data, romf(14'(16 + c - 2)));
                chk("t1_id", rd_id, 2);
            end
            chk("t1_last", rd_last, c == 5);
            chk("t1_done", done, (c == 5) ? 4'b0100 : 4'b0000);
            if (c == 5) req[2] = 1'b0;
        end

        // 2: all four requesting continuously from a fresh pointer
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) post(i, 14'(32 * i), 8'd2);
        n = 0; cyc = 0; overlap = 0; prev = '0;
        while (n < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if ($countones(grant) > 1) overlap++;
            if (grant != 0 && grant != prev) begin
                got[n] = grant;
                n++;
            end
            prev = grant;
        end
        req = '0;
        chk("t2_count", n, 5);
        for (int k = 0; k < 5; k++) chk("t2_order", got[k], 4'b0001 << (k % 4));
        chk("t2_overlap", overlap, 0);
        wait_idle();

        // 3: address wrap at 2**14
        burst(1, 14'h3FFE, 8'd4);

        // 4: zero-length burst
        @(negedge clk);
        post(3, 14'h0100, 8'd0);
        @(negedge clk);
        chk("t4_grant", grant, 4'b1000);
        chk("t4_done", done, 4'b1000);
        chk("t4_rden", rom_rden, 0);
        chk("t4_valid", rd_valid, 0);
        req[3] = 1'b0;
        @(negedge clk);
        chk("t4_grant_off", grant, 0);
        chk("t4_done_off", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_valid2", rd_valid, 0);
        chk("t4_rden2", rom_rden, 0);

        // 5: two-cycle ROM latency
        req2[0] = 1'b1;
        req_addr2[13:0] = 14'h0100;
        req_len2[7:0] = 8'd3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t5_grant", grant2, (c <= 5) ? 4'b0001 : 4'b0000);
            chk("t5_rden", rom_rden2, c <= 3);
            if (c <= 3) chk("t5_addr", rom_address2, 14'h0100 + c - 1);
            chk("t5_valid", rd_valid2, (c >= 3) && (c <= 5));
            if (c >= 3 && c <= 5) chk("t5_data", rd_data2, romf(14'(256 + c - 3)));
            chk("t5_last", rd_last2, c == 5);
            chk("t5_done", done2, (c == 5) ? 4'b0001 : 4'b0000);
            if (c == 5) req2[0] = 1'b0;
        end

        // 6: reset during beat 2 of 5, then pointer must restart at requester 0
        @(negedge clk);
        post(2, 14'h0200, 8'd5);
        for (int c = 1; c <= 3; c++) @(negedge clk);
        chk("t6_beat2", rd_data, romf(14'h0201));
        chk("t6_valid", rd_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rden", rom_rden, 0);
        chk("t6_rst_addr", rom_address, 0);
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_last", rd_last, 0);
        chk("t6_rst_done", done, 0);
        req = '0;
        @(negedge clk);
        chk("t6_rst_done2", done, 0);
        chk("t6_rst_valid2", rd_valid, 0);
        reset_n = 1'b1;
        post(0, 14'h0005, 8'd1);
        post(3, 14'h0007, 8'd1);
        @(negedge clk);
        chk("t6_grant0", grant, 4'b0001);
        chk("t6_addr0", rom_address, 14'h0005);
        @(negedge clk);
        chk("t6_data0", rd_data, romf(14'h0005));
        chk("t6_done0", done, 4'b0001);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t6_gap", grant, 0);
        @(negedge clk);
        chk("t6_grant3", grant, 4'b1000);
        req[3] = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
